// File: rtl/speed_pkg.sv
// Shared types and default sizing for the speed estimator.
package speed_pkg;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int SPEED_W_DEF  = 16;
   localparam int AVG_LOG2_DEF = 2;
   localparam int COUNT_W      = 32;

endpackage

// File: rtl/period_tick.sv
// Sample-window timer: counts 0..PERIOD_CYCLES-1 and flags the last cycle.
module period_tick #(
   parameter int PERIOD_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   // Next count: wrap after the last cycle, restart on clr.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (tick) cnt_d = '0;
      if (clr)  cnt_d = '0;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/speed_estimator.sv
// Encoder speed estimator: per-window position delta, saturated and averaged.
//
//   state | meaning
//   INIT  | waiting for the first tick to capture a reference position
//   FILL  | producing samples while the history still holds zero entries
//   RUN   | history full of real samples, primed asserted
module speed_estimator #(
   parameter int PERIOD_CYCLES = 500000,
   parameter int SPEED_W       = speed_pkg::SPEED_W_DEF,
   parameter int AVG_LOG2      = speed_pkg::AVG_LOG2_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [31:0]        count,
   input  logic                      clr,
   output logic signed [SPEED_W-1:0] speed,
   output logic                      speed_valid,
   output logic                      sat,
   output logic                      primed
);
   import speed_pkg::*;

   localparam int DEPTH  = 1 << AVG_LOG2;
   localparam int SUM_W  = SPEED_W + AVG_LOG2;
   localparam int FILL_W = 4;
   localparam logic signed [31:0] SAT_MAX = 32'((64'sd1 <<< (SPEED_W - 1)) - 64'sd1);
   localparam logic signed [31:0] SAT_MIN = -SAT_MAX - 32'sd1;

   logic                      tick;
   state_t                    state_q, state_d;
   logic signed [31:0]        prev_q, prev_d;
   logic signed [SPEED_W-1:0] hist_q [DEPTH];
   logic signed [SPEED_W-1:0] hist_d [DEPTH];
   logic signed [SUM_W-1:0]   sum_q, sum_d;
   logic signed [SPEED_W-1:0] speed_q, speed_d;
   logic                      valid_q, valid_d;
   logic                      sat_q, sat_d;
   logic                      primed_q, primed_d;
   logic [FILL_W-1:0]         fill_q, fill_d;

   logic signed [31:0]        delta;
   logic signed [SPEED_W-1:0] delta_sat;
   logic                      sat_hit;
   logic signed [SUM_W-1:0]   sum_new;

   period_tick #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_period_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .tick  (tick)
   );

   // Window delta (modulo 2^32 so counter wrap gives the small true delta), clamped.
   always_comb begin
      delta     = count - prev_q;
      sat_hit   = 1'b0;
      delta_sat = delta[SPEED_W-1:0];
      if (delta > SAT_MAX) begin
         delta_sat = SAT_MAX[SPEED_W-1:0];
         sat_hit   = 1'b1;
      end else if (delta < SAT_MIN) begin
         delta_sat = SAT_MIN[SPEED_W-1:0];
         sat_hit   = 1'b1;
      end
      sum_new = sum_q + SUM_W'(delta_sat) - SUM_W'(hist_q[DEPTH-1]);
   end

   // Next-state and datapath update; clr wins over tick.
   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      hist_d   = hist_q;
      sum_d    = sum_q;
      speed_d  = speed_q;
      valid_d  = 1'b0;
      sat_d    = sat_q;
      primed_d = primed_q;
      fill_d   = fill_q;
      if (clr) begin
         state_d  = INIT;
         prev_d   = '0;
         hist_d   = '{default: '0};
         sum_d    = '0;
         speed_d  = '0;
         sat_d    = 1'b0;
         primed_d = 1'b0;
         fill_d   = '0;
      end else if (tick) begin
         case (state_q)
            INIT: begin
               prev_d  = count;
               fill_d  = '0;
               state_d = FILL;
            end
            FILL, RUN: begin
               prev_d = count;
               for (int i = DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
               hist_d[0] = delta_sat;
               sum_d     = sum_new;
               // Taking the upper SPEED_W bits is the floor-toward-minus-infinity divide.
               speed_d   = sum_new[AVG_LOG2 +: SPEED_W];
               valid_d   = 1'b1;
               if (sat_hit) sat_d = 1'b1;
               if (state_q == FILL) begin
                  if (fill_q == FILL_W'(DEPTH - 1)) begin
                     primed_d = 1'b1;
                     state_d  = RUN;
                  end else begin
                     fill_d = fill_q + FILL_W'(1);
                  end
               end
            end
            default: state_d = INIT;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= INIT;
         prev_q   <= '0;
         hist_q   <= '{default: '0};
         sum_q    <= '0;
         speed_q  <= '0;
         valid_q  <= 1'b0;
         sat_q    <= 1'b0;
         primed_q <= 1'b0;
         fill_q   <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         hist_q   <= hist_d;
         sum_q    <= sum_d;
         speed_q  <= speed_d;
         valid_q  <= valid_d;
         sat_q    <= sat_d;
         primed_q <= primed_d;
         fill_q   <= fill_d;
      end
   end

   assign speed       = speed_q;
   assign speed_valid = valid_q;
   assign sat         = sat_q;
   assign primed      = primed_q;

endmodule

// File: tb/tb_speed_estimator.sv
// Self-checking bench for speed_estimator with a queue-based averaging model.
module tb_speed_estimator;

   localparam int PER   = 10;
   localparam int SW    = 16;
   localparam int AL    = 2;
   localparam int DEPTH = 1 << AL;
   localparam longint SMAX = (longint'(1) <<< (SW - 1)) - 1;
   localparam longint SMIN = -SMAX - 1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 clr = 1'b0;
   logic signed [31:0]   count = '0;
   logic signed [SW-1:0] speed;
   logic                 speed_valid;
   logic                 sat;
   logic                 primed;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit                 m_started;
   logic signed [31:0] m_prev;
   longint             m_hist[$];
   int                 m_nsamp;
   bit                 m_sat;
   longint             m_speed;
   bit                 m_primed;

   speed_estimator #(.PERIOD_CYCLES(PER), .SPEED_W(SW), .AVG_LOG2(AL)) dut (
      .clk         (clk),
      .reset       (reset),
      .count       (count),
      .clr         (clr),
      .speed       (speed),
      .speed_valid (speed_valid),
      .sat         (sat),
      .primed      (primed)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      m_started = 0;
      m_prev    = '0;
      m_hist.delete();
      repeat (DEPTH) m_hist.push_back(0);
      m_nsamp  = 0;
      m_sat    = 0;
      m_speed  = 0;
      m_primed = 0;
   endfunction

   // Applies one window boundary with position c; returns 1 if an update is due.
   function automatic bit model_tick(input logic signed [31:0] c);
      logic signed [31:0] d32;
      longint d, sum, q;
      if (!m_started) begin
         m_started = 1;
         m_prev    = c;
         return 0;
      end
      d32    = c - m_prev;
      m_prev = c;
      d      = longint'(d32);
      if (d > SMAX) begin d = SMAX; m_sat = 1; end
      else if (d < SMIN) begin d = SMIN; m_sat = 1; end
      m_hist.push_front(d);
      void'(m_hist.pop_back());
      sum = 0;
      foreach (m_hist[i]) sum += m_hist[i];
      q = sum / DEPTH;
      if (sum < 0 && (sum % DEPTH) != 0) q = q - 1;
      m_speed = q;
      m_nsamp++;
      if (m_nsamp >= DEPTH) m_primed = 1;
      return 1;
   endfunction

   // One full window starting right after a counter restart or tick edge.
   // count is noisy until the cycle before the tick edge, then holds c.
   task automatic run_window(input logic signed [31:0] c, output logic v,
                             output logic signed [SW-1:0] spd, output logic s,
                             output logic p, output int mid_pulses,
                             output int mid_changes, output logic signed [SW-1:0] mid_spd);
      logic signed [SW-1:0] last;
      mid_pulses  = 0;
      mid_changes = 0;
      last        = '0;
      mid_spd     = '0;
      for (int i = 0; i < PER - 1; i++) begin
         count = (i < PER - 2) ? $urandom : c;
         edge1();
         if (speed_valid !== 1'b0) mid_pulses++;
         if (i == 0) mid_spd = speed;
         else if (speed !== last) mid_changes++;
         last = speed;
      end
      edge1();
      v   = speed_valid;
      spd = speed;
      s   = sat;
      p   = primed;
   endtask

   task automatic test_reset();
      repeat (3) edge1();
      checks++; if (speed !== '0)        begin errors++; $display("FAIL reset_speed: got %0d want 0", speed); end
      checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", speed_valid); end
      checks++; if (sat !== 1'b0)         begin errors++; $display("FAIL reset_sat: got %b want 0", sat); end
      checks++; if (primed !== 1'b0)      begin errors++; $display("FAIL reset_primed: got %b want 0", primed); end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_ramp();
      logic v, s, p; logic signed [SW-1:0] spd, mspd, es, ps; int mp, mc; bit ev; logic signed [31:0] c;
      for (int k = 0; k < 7; k++) begin
         c = 32'(k * 5);
         run_window(c, v, spd, s, p, mp, mc, mspd);
         ps = SW'(m_speed);
         ev = model_tick(c);
         es = SW'(m_speed);
         checks++; if (v !== ev)            begin errors++; $display("FAIL ramp_valid w%0d: got %b want %b", k, v, ev); end
         checks++; if (spd !== es)          begin errors++; $display("FAIL ramp_speed w%0d: got %0d want %0d", k, spd, es); end
         checks++; if (p !== m_primed)      begin errors++; $display("FAIL ramp_primed w%0d: got %b want %b", k, p, m_primed); end
         checks++; if (s !== m_sat)         begin errors++; $display("FAIL ramp_sat w%0d: got %b want %b", k, s, m_sat); end
         checks++; if (mp !== 0)            begin errors++; $display("FAIL ramp_midpulse w%0d: got %0d want 0", k, mp); end
         checks++; if (mc !== 0 || mspd !== ps) begin errors++; $display("FAIL ramp_hold w%0d: got %0d/%0d want 0/%0d", k, mc, mspd, ps); end
      end
   endtask

   task automatic test_reset_in_run();
      logic v, s, p; logic signed [SW-1:0] spd, mspd, es; int mp, mc; bit ev; logic signed [31:0] c;
      // reset on the cycle the pulse is visible
      c = 32'd100;
      run_window(c, v, spd, s, p, mp, mc, mspd);
      ev = model_tick(c);
      checks++; if (v !== ev) begin errors++; $display("FAIL pre_reset_valid: got %b want %b", v, ev); end
      reset = 1'b1;
      edge1();
      reset = 1'b0;
      model_clear();
      checks++; if (speed_valid !== 1'b0 || speed !== '0) begin errors++; $display("FAIL reset_on_pulse: got v=%b s=%0d want 0/0", speed_valid, speed); end
      // prime again, then reset 3 cycles into a window
      for (int k = 0; k < 6; k++) begin
         c = 32'(k * 9);
         run_window(c, v, spd, s, p, mp, mc, mspd);
         ev = model_tick(c);
      end
      checks++; if (primed !== 1'b1) begin errors++; $display("FAIL run_primed: got %b want 1", primed); end
      repeat (3) edge1();
      reset = 1'b1;
      edge1();
      reset = 1'b0;
      model_clear();
      checks++; if (speed !== '0 || speed_valid !== 1'b0 || sat !== 1'b0 || primed !== 1'b0)
         begin errors++; $display("FAIL reset_mid_run: got s=%0d v=%b sat=%b p=%b want all 0", speed, speed_valid, sat, primed); end
      for (int k = 0; k < 2; k++) begin
         c = 32'(500 + k * 21);
         run_window(c, v, spd, s, p, mp, mc, mspd);
         ev = model_tick(c);
         es = SW'(m_speed);
         checks++; if (v !== ev || mp !== 0) begin errors++; $display("FAIL post_reset_valid w%0d: got %b/%0d want %b/0", k, v, mp, ev); end
         checks++; if (spd !== es)           begin errors++; $display("FAIL post_reset_speed w%0d: got %0d want %0d", k, spd, es); end
      end
   endtask

   task automatic test_const_neg();
      logic v, s, p; logic signed [SW-1:0] spd, mspd, es; int mp, mc; bit ev; logic signed [31:0] c;
      clr = 1'b1; edge1(); clr = 1'b0;
      model_clear();
      for (int k = 0; k < 7; k++) begin
         c = 32'(-12 * k);
         run_window(c, v, spd, s, p, mp, mc, mspd);
         ev = model_tick(c);
         es = SW'(m_speed);
         checks++; if (v !== ev)       begin errors++; $display("FAIL neg_valid w%0d: got %b want %b", k, v, ev); end
         checks++; if (spd !== es)     begin errors++; $display("FAIL neg_speed w%0d: got %0d want %0d", k, spd, es); end
         checks++; if (p !== m_primed) begin errors++; $display("FAIL neg_primed w%0d: got %b want %b", k, p, m_primed); end
         checks++; if (mp !== 0 || mc !== 0) begin errors++; $display("FAIL neg_mid w%0d: got %0d/%0d want 0/0", k, mp, mc); end
      end
   endtask

   task automatic test_clr_on_tick();
      logic v, s, p; logic signed [SW-1:0] spd, mspd, es; int mp, mc; bit ev; logic signed [31:0] c;
      repeat (PER - 1) edge1();
      count = 32'sd1000;
      clr = 1'b1;
      edge1();
      clr = 1'b0;
      model_clear();
      checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL clr_tick_valid: got %b want 0", speed_valid); end
      checks++; if (speed !== '0)         begin errors++; $display("FAIL clr_tick_speed: got %0d want 0", speed); end
      checks++; if (primed !== 1'b0)      begin errors++; $display("FAIL clr_tick_primed: got %b want 0", primed); end
      for (int k = 0; k < 2; k++) begin
         c = 32'(-77 + 7 * k);
         run_window(c, v, spd, s, p, mp, mc, mspd);
         ev = model_tick(c);
         es = SW'(m_speed);
         checks++; if (v !== ev || mp !== 0) begin errors++; $display("FAIL clr_next_valid w%0d: got %b/%0d want %b/0", k, v, mp, ev); end
         checks++; if (spd !== es)           begin errors++; $display("FAIL clr_next_speed w%0d: got %0d want %0d", k, spd, es); end
      end
   endtask

   task automatic test_wrap();
      logic v, s, p; logic signed [SW-1:0] spd, mspd, es; int mp, mc; bit ev;
      logic signed [31:0] cs [2];
      clr = 1'b1; edge1(); clr = 1'b0;
      model_clear();
      cs[0] = 32'h7FFF_FFFE;
      cs[1] = 32'h8000_0003;
      for (int k = 0; k < 2; k++) begin
         run_window(cs[k], v, spd, s, p, mp, mc, mspd);
         ev = model_tick(cs[k]);
         es = SW'(m_speed);
         checks++; if (v !== ev)    begin errors++; $display("FAIL wrap_valid w%0d: got %b want %b", k, v, ev); end
         checks++; if (spd !== es)  begin errors++; $display("FAIL wrap_speed w%0d: got %0d want %0d", k, spd, es); end
         checks++; if (s !== m_sat) begin errors++; $display("FAIL wrap_sat w%0d: got %b want %b", k, s, m_sat); end
      end
   endtask

   task automatic test_saturate();
      logic v, s, p; logic signed [SW-1:0] spd, mspd, es; int mp, mc; bit ev;
      logic signed [31:0] cs [5];
      clr = 1'b1; edge1(); clr = 1'b0;
      model_clear();
      cs[0] = 32'sd0; cs[1] = 32'sd40000; cs[2] = 32'sd40010; cs[3] = -32'sd59990; cs[4] = -32'sd59980;
      for (int k = 0; k < 5; k++) begin
         run_window(cs[k], v, spd, s, p, mp, mc, mspd);
         ev = model_tick(cs[k]);
         es = SW'(m_speed);
         checks++; if (v !== ev)    begin errors++; $display("FAIL sat_valid w%0d: got %b want %b", k, v, ev); end
         checks++; if (spd !== es)  begin errors++; $display("FAIL sat_speed w%0d: got %0d want %0d", k, spd, es); end
         checks++; if (s !== m_sat) begin errors++; $display("FAIL sat_flag w%0d: got %b want %b", k, s, m_sat); end
      end
      repeat (4) edge1();
      clr = 1'b1; edge1(); clr = 1'b0;
      model_clear();
      checks++; if (sat !== 1'b0 || speed !== '0) begin errors++; $display("FAIL sat_clr: got sat=%b s=%0d want 0/0", sat, speed); end
   endtask

   task automatic test_random();
      logic v, s, p; logic signed [SW-1:0] spd, mspd, es, ps; int mp, mc; bit ev; int r, n;
      logic signed [31:0] c, step;
      c = $urandom;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            n = $urandom_range(0, PER - 1);
            repeat (n) edge1();
            clr = 1'b1; edge1(); clr = 1'b0;
            model_clear();
            checks++; if (speed_valid !== 1'b0 || speed !== '0 || primed !== 1'b0 || sat !== 1'b0)
               begin errors++; $display("FAIL rnd_clr w%0d: got v=%b s=%0d p=%b sat=%b want all 0", k, speed_valid, speed, primed, sat); end
         end
         r = $urandom_range(0, 9);
         if (r == 0)      step = $urandom;
         else if (r == 1) step = 32'(int'($urandom_range(0, 80000)) - 40000);
         else             step = 32'(int'($urandom_range(0, 400)) - 200);
         c = c + step;
         run_window(c, v, spd, s, p, mp, mc, mspd);
         ps = SW'(m_speed);
         ev = model_tick(c);
         es = SW'(m_speed);
         checks++; if (v !== ev)       begin errors++; $display("FAIL rnd_valid w%0d: got %b want %b", k, v, ev); end
         checks++; if (spd !== es)     begin errors++; $display("FAIL rnd_speed w%0d: got %0d want %0d", k, spd, es); end
         checks++; if (s !== m_sat)    begin errors++; $display("FAIL rnd_sat w%0d: got %b want %b", k, s, m_sat); end
         checks++; if (p !== m_primed) begin errors++; $display("FAIL rnd_primed w%0d: got %b want %b", k, p, m_primed); end
         checks++; if (mp !== 0 || mc !== 0 || mspd !== ps)
            begin errors++; $display("FAIL rnd_hold w%0d: got %0d/%0d/%0d want 0/0/%0d", k, mp, mc, mspd, ps); end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_ramp();
      test_reset_in_run();
      test_const_neg();
      test_clr_on_tick();
      test_wrap();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/speed_estimator.md
SPEED_ESTIMATOR -- requirements
Module: speed_estimator

Interface
REQ-001 The module SHALL have parameter PERIOD_CYCLES, default 500000, giving clk cycles per sample window (10 ms at 50 MHz); legal range 2..2^24.
REQ-002 The module SHALL have parameter SPEED_W, default 16, giving the width of the signed speed output.
REQ-003 The module SHALL have parameter AVG_LOG2, default 2, giving the moving-average depth of 2^AVG_LOG2 samples; legal range 0..3.
REQ-004 Port: clk  input  1  system clock; all logic on posedge clk.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: count  input  32  signed encoder position from quad_dec, already synchronous to clk.
REQ-007 Port: clr  input  1  synchronous restart of the estimator without a full reset.
REQ-008 Port: speed  output  SPEED_W  signed averaged counts per window, registered.
REQ-009 Port: speed_valid  output  1  one-cycle pulse when speed updates.
REQ-010 Port: sat  output  1  sticky flag, set when any window delta saturated.
REQ-011 Port: primed  output  1  high once the history holds 2^AVG_LOG2 real samples.

Function
REQ-012 A window counter SHALL run 0..PERIOD_CYCLES-1 and wrap; tick SHALL be asserted in the cycle the counter equals PERIOD_CYCLES-1.
REQ-013 The FSM SHALL have states INIT, FILL and RUN; reset and clr SHALL both enter INIT.
REQ-014 INIT, on tick: latch count into prev and go to FILL; no delta is computed and speed_valid stays 0.
REQ-015 FILL/RUN, on tick: delta = count - prev in 32-bit two's-complement arithmetic (wrap-around of count yields the correct small delta); prev <= count.
REQ-016 Delta SHALL be saturated to [-2^(SPEED_W-1), 2^(SPEED_W-1)-1]; saturation SHALL set sat, which is cleared only by reset or clr.
REQ-017 The saturated delta SHALL be shifted into a 2^AVG_LOG2-entry history; the running sum SHALL be SPEED_W+AVG_LOG2 bits wide, updated as sum + new - oldest.
REQ-018 speed SHALL equal sum arithmetically shifted right by AVG_LOG2 (floor toward -inf) and SHALL update exactly 1 cycle after the tick cycle, with speed_valid high for that one cycle.
REQ-019 FILL SHALL count samples; after the 2^AVG_LOG2-th sample it SHALL assert primed and go to RUN. Outputs in FILL are valid but average against zero-filled entries.
REQ-020 clr SHALL take priority over tick in the same cycle: counter <= 0, history and sum <= 0, speed <= 0, sat <= 0, primed <= 0, and no speed_valid pulse.
REQ-021 speed SHALL hold its value between updates; count changes between ticks SHALL have no effect.

Reset
REQ-022 With reset high at a clk edge: state INIT, window counter 0, prev 0, history 0, sum 0, speed 0, speed_valid 0, sat 0, primed 0.
REQ-023 Reset asserted mid-window or during the speed_valid cycle SHALL abort it; no pulse SHALL appear in the cycle after reset.
REQ-024 reset SHALL take priority over clr.

Structure
REQ-025 Package speed_pkg SHALL hold the state typedef (INIT, FILL, RUN) and the default SPEED_W/AVG_LOG2 constants.
REQ-026 The window counter SHALL be a sub-module period_tick (params PERIOD_CYCLES; ports clk, reset, clr, tick).
REQ-027 Saturation and averaging SHALL stay in speed_estimator.

Verification (PERIOD_CYCLES=10, SPEED_W=16, AVG_LOG2=2)
REQ-028 count ramps +5 per window from 0 -> first speed_valid at the 2nd tick +1 cycle; speeds 1,2,3,5,5 (floor of 5/4, 10/4, 15/4, then 20/4); primed rises with the 4th sample.
REQ-029 count constant -12 per window -> steady speed -12; during fill -3,-6,-9,-12.
REQ-030 count steps from 0x7FFFFFFE to 0x80000003 across one window -> delta +5, no sat.
REQ-031 count jumps +40000 in one window -> delta saturates to 32767, sat=1 and stays 1 until clr.
REQ-032 clr asserted on a tick cycle -> no speed_valid, speed=0, primed=0, state INIT; next tick only latches prev.
REQ-033 reset asserted 3 cycles into RUN -> all outputs 0 next cycle; first speed_valid returns 2 windows after release.
